lsu_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared byte-wide data memory. It accepts word instruction-fetch reads and byte/half/word data loads and stores, grants one requester at a time with round-robin fairness, and serialises each access into one memory byte cycle per byte. It assembles little-endian read data and sign- or zero-extends it. It sits between the fetch/LSU stages and the byte memory array, which reads combinationally and writes on the clock edge.

---
 rtl/lsu_mem_arbiter_if.sv | 34 +++
 rtl/lsu_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_arbiter_if.sv
// Bundle for the fetch port, the data port and the byte-wide memory port of lsu_mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface lsu_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic [31:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_we, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_we, m_wdata, busy
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter between instruction fetch and LSU data accesses, serialising each
// access into byte cycles on a shared byte-wide memory and assembling little-endian results.
module lsu_mem_arbiter (
    input  logic                clock,
    input  logic                reset,
    lsu_mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;            // 1 = data port owns the transfer
    logic        last_data_q, last_data_d;  // 1 = data port was served last
    logic [31:0] base_q, base_d;
    logic [1:0]  last_q, last_d;            // index of the final byte (N-1)
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_data;
    logic [31:0] asm_next;
    logic [31:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata;

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] last,
                                           input logic uns);
        case (last)
            2'd0:    return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'd1:    return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Ties go to whichever port was not served last.
    assign grant_data = bus.d_req && (!bus.i_req || !last_data_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        port_d      = port_q;
        last_data_d = last_data_q;
        base_d      = base_q;
        last_d      = last_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        m_addr      = 32'h0;
        m_we        = 1'b0;
        m_wdata     = 8'h0;
        asm_next    = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = bus.m_rdata;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    port_d  = grant_data;
                    base_d  = grant_data ? bus.d_addr : bus.i_addr;
                    last_d  = grant_data ? last_idx(bus.d_size) : 2'd3;
                    we_d    = grant_data && bus.d_we;
                    uns_d   = grant_data && bus.d_unsigned;
                    wdata_d = grant_data ? bus.d_wdata : 32'h0;
                    cnt_d   = 2'd0;
                    asm_d   = 32'h0;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_addr  = base_q + {30'h0, cnt_q};
                m_we    = we_q;
                m_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
                cnt_d   = cnt_q + 2'd1;
                if (!we_q) asm_d = asm_next;
                if (cnt_q == last_q) begin
                    state_d     = DONE;
                    last_data_d = port_q;
                    if (!we_q) begin
                        if (port_q) d_rdata_d = extend(asm_next, last_q, uns_q);
                        else        i_rdata_d = asm_next;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            last_data_q <= 1'b0;
            base_q      <= 32'h0;
            last_q      <= 2'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0;
            cnt_q       <= 2'd0;
            asm_q       <= 32'h0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q     <= state_d;
            port_q      <= port_d;
            last_data_q <= last_data_d;
            base_q      <= base_d;
            last_q      <= last_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.i_ack   = (state_q == DONE) && !port_q;
    assign bus.d_ack   = (state_q == DONE) && port_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_addr  = m_addr;
    assign bus.m_we    = m_we;
    assign bus.m_wdata = m_wdata;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: byte memory model, hand-computed expectations,
// immediate assertions at each comparison point.
module tb_lsu_mem_arbiter;
    logic clock;
    logic reset;
    lsu_mem_arbiter_if bus ();

    lsu_mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Byte memory: combinational read, write on the rising edge.
    assign bus.m_rdata = mem[bus.m_addr[7:0]];
    always @(posedge clock) begin
        if (bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE, returns at the negedge after the ack (IDLE again).
    task automatic data_op(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat);
        bus.d_we       = we;
        bus.d_size     = size;
        bus.d_unsigned = uns;
        bus.d_addr     = addr;
        bus.d_wdata    = wdata;
        bus.d_req      = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!bus.d_ack && lat < 20);
        bus.d_req = 1'b0;
        rdata = bus.d_rdata;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic [31:0] sw_data;
        logic [31:0] wrap_addr [4];
        int          n;
        int          ack_port [4];
        int          ack_cyc  [4];
        int          exp_port [4];

        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset defaults
        check("rst i_ack",   {31'h0, bus.i_ack}, 32'h0);
        check("rst d_ack",   {31'h0, bus.d_ack}, 32'h0);
        check("rst i_rdata", bus.i_rdata, 32'h0);
        check("rst d_rdata", bus.d_rdata, 32'h0);
        check("rst m_addr",  bus.m_addr, 32'h0);
        check("rst m_we",    {31'h0, bus.m_we}, 32'h0);
        check("rst m_wdata", {24'h0, bus.m_wdata}, 32'h0);
        check("rst busy",    {31'h0, bus.busy}, 32'h0);

        // Word store 0x8899AABB at 0x10, byte by byte
        sw_data = 32'h8899AABB;
        bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'h10; bus.d_wdata = sw_data;
        bus.d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("sw m_addr",  bus.m_addr, 32'h10 + k);
            check("sw m_we",    {31'h0, bus.m_we}, 32'h1);
            check("sw m_wdata", {24'h0, bus.m_wdata}, {24'h0, sw_data[8*k +: 8]});
            check("sw no ack",  {31'h0, bus.d_ack}, 32'h0);
        end
        @(negedge clock);
        check("sw d_ack",     {31'h0, bus.d_ack}, 32'h1);
        check("sw done m_we", {31'h0, bus.m_we}, 32'h0);
        check("sw done busy", {31'h0, bus.busy}, 32'h1);
        bus.d_req = 1'b0;
        @(negedge clock);
        check("sw ack drop",  {31'h0, bus.d_ack}, 32'h0);
        check("sw idle busy", {31'h0, bus.busy}, 32'h0);
        check("sw mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h8899AABB);

        // Signed / unsigned byte loads
        data_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r, lat);
        check("lb rdata", r, 32'hFFFFFF88);
        check("lb lat", lat, 2);
        data_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, r, lat);
        check("lbu rdata", r, 32'h00000088);

        // Misaligned half loads
        data_op(1'b1, 2'b00, 1'b0, 32'h21, 32'hABCDEF34, r, lat);
        check("sb lat", lat, 2);
        data_op(1'b1, 2'b00, 1'b0, 32'h22, 32'h00000092, r, lat);
        data_op(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, r, lat);
        check("lh rdata", r, 32'hFFFF9234);
        check("lh lat", lat, 3);
        data_op(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, r, lat);
        check("lhu rdata", r, 32'h00009234);
        data_op(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055, r, lat);
        check("store keeps d_rdata", bus.d_rdata, 32'h00009234);
        check("fetch rdata idle", bus.i_rdata, 32'h0);
        check("sb mem", {24'h0, mem[8'h30]}, 32'h55);

        // Hold semantics: d_addr moves mid-transfer, d_req held past the ack
        bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_unsigned = 1'b0; bus.d_addr = 32'h10;
        bus.d_req = 1'b1;
        @(negedge clock);
        check("hold m_addr0", bus.m_addr, 32'h10);
        bus.d_addr = 32'h21;
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            check("hold m_addr", bus.m_addr, 32'h10 + k);
        end
        @(negedge clock);
        check("hold d_ack",   {31'h0, bus.d_ack}, 32'h1);
        check("hold d_rdata", bus.d_rdata, 32'h8899AABB);
        bus.d_addr = 32'h10;
        @(negedge clock);
        check("hold idle busy", {31'h0, bus.busy}, 32'h0);
        check("hold idle ack",  {31'h0, bus.d_ack}, 32'h0);
        @(negedge clock);
        check("hold again busy",   {31'h0, bus.busy}, 32'h1);
        check("hold again m_addr", bus.m_addr, 32'h10);
        bus.d_req = 1'b0;
        repeat (4) @(negedge clock);
        check("hold again ack",    {31'h0, bus.d_ack}, 32'h1);
        check("hold again rdata",  bus.d_rdata, 32'h8899AABB);
        @(negedge clock);

        // Address wrap on store and fetch
        data_op(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h44332211, r, lat);
        check("wrap sw lat", lat, 5);
        wrap_addr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        bus.i_addr = 32'hFFFFFFFE;
        bus.i_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("wrap m_addr", bus.m_addr, wrap_addr[k]);
            check("wrap m_we",   {31'h0, bus.m_we}, 32'h0);
        end
        @(negedge clock);
        check("wrap i_ack",   {31'h0, bus.i_ack}, 32'h1);
        check("wrap d_ack",   {31'h0, bus.d_ack}, 32'h0);
        check("wrap i_rdata", bus.i_rdata, 32'h44332211);
        check("wrap d_rdata", bus.d_rdata, 32'h8899AABB);
        bus.i_req = 1'b0;
        @(negedge clock);

        // Reset in the middle of a word store
        bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
        bus.d_req = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        check("abort busy", {31'h0, bus.busy}, 32'h0);
        check("abort m_we", {31'h0, bus.m_we}, 32'h0);
        @(negedge clock);
        check("abort busy next", {31'h0, bus.busy}, 32'h0);
        check("abort no ack",    {31'h0, bus.d_ack}, 32'h0);
        check("abort d_rdata",   bus.d_rdata, 32'h0);
        check("abort mem", {16'h0, mem[8'h41], mem[8'h40]}, 32'h0000BEEF);

        // Arbitration with both requesters held from reset
        bus.i_addr = 32'h10;
        bus.d_we = 1'b0; bus.d_size = 2'b01; bus.d_unsigned = 1'b1; bus.d_addr = 32'h21;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            ack_port[k] = 2;
            ack_cyc[k]  = -100;
        end
        exp_port = '{1, 0, 1, 0};
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            @(negedge clock);
            if (bus.d_ack || bus.i_ack) begin
                check("arb single port", {31'h0, bus.d_ack & bus.i_ack}, 32'h0);
                ack_port[n] = bus.d_ack ? 1 : 0;
                ack_cyc[n]  = cyc;
                if (n == 0) begin
                    check("arb1 d_rdata", bus.d_rdata, 32'h00009234);
                    check("arb1 i_rdata", bus.i_rdata, 32'h0);
                end else if (n == 1) begin
                    check("arb2 i_rdata", bus.i_rdata, 32'h8899AABB);
                    check("arb2 d_rdata", bus.d_rdata, 32'h00009234);
                end
                n++;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("arb ack count", n, 4);
        for (int k = 0; k < 4; k++) check("arb order", ack_port[k], exp_port[k]);
        check("arb first ack", ack_cyc[0], 2);
        check("arb gap d-f", ack_cyc[1] - ack_cyc[0], 6);
        check("arb gap f-d", ack_cyc[2] - ack_cyc[1], 4);
        check("arb gap d-f2", ack_cyc[3] - ack_cyc[2], 6);
        repeat (2) @(negedge clock);
        check("arb end busy", {31'h0, bus.busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
